add_sub_multiword_seq: RTL
==========================

# add_sub_multiword_seq

Word-serial multi-precision adder/subtractor that feeds the `add_sub_binary` stage and consumes its outputs. It accepts two `WORD_COUNT*WORD_WIDTH`-bit operands over a valid/ready handshake. It runs them through one `add_sub_binary` instance one word per cycle, least-significant word first, chaining the carry through a register. It returns the full-width result with carry/borrow and signed overflow over a second valid/ready handshake.

## Interface
- `WORD_WIDTH`, default 8: width of one word and of the internal `add_sub_binary` instance; must be ≥2.
- `WORD_COUNT`, default 4: number of words per operand; must be ≥2.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `in_valid_i`  in  1  operation request.
- `in_ready_o`  out  1  block can accept an operation.
- `add_sub_i`  in  1  0 selects A+B+cin; 1 selects A−B−cin, where `carry_in_i` acts as a borrow.
- `carry_in_i`  in  1  carry in (add) or borrow in (subtract).
- `A_i`  in  WORD_COUNT*WORD_WIDTH  operand A.
- `B_i`  in  WORD_COUNT*WORD_WIDTH  operand B.
- `out_valid_o`  out  1  result available.
- `out_ready_i`  in  1  consumer takes the result.
- `sum_o`  out  WORD_COUNT*WORD_WIDTH  result.
- `carry_out_o`  out  1  carry out of the top word (add); borrow out of the top word (subtract).
- `overflow_o`  out  1  two's-complement overflow of the full-width operation.

## Operation
- States:
  - IDLE: `in_ready_o`=1.
  - RUN: word index `k` runs 0..WORD_COUNT−1.
  - DONE: `out_valid_o`=1.
- IDLE→RUN on `in_valid_i && in_ready_o`. At that edge:
  - `A_i` and `B_i` are captured into shift registers.
  - `add_sub_i` is latched.
  - The carry register is loaded with `carry_in_i` for add, or `~carry_in_i` for subtract.
  - `k` is set to 0.
- RUN datapath:
  - The `add_sub_binary` instance is always driven with `add_sub_i`=0.
  - Its `A_i` input gets word k of A.
  - Its `B_i` input gets word k of B, bitwise inverted when subtracting.
  - Its `carry_in_i` input gets the carry register.
  - Each cycle: `sum_o` of the instance is shifted into the result register at word k, the carry register takes `carry_out_o`, and `k` increments.
- RUN→DONE on the edge that processes k=WORD_COUNT−1. At that edge:
  - `overflow_o` is latched from the instance's `overflow_o`.
  - `carry_out_o` is latched as the final carry for add, or its inverse (borrow) for subtract.
- DONE→IDLE on `out_ready_i` (see Configuration for direct DONE→RUN).
- While in DONE, `sum_o`, `carry_out_o` and `overflow_o` hold stable until the handshake.
- Inputs are ignored outside the accepting cycle; `A_i`/`B_i` may change freely during RUN.
- The result is identical to a single `WORD_COUNT*WORD_WIDTH`-bit `add_sub_binary` evaluation with the same `add_sub_i` and `carry_in_i`.
- Wrap-around: results are modulo 2^(WORD_COUNT*WORD_WIDTH); the carry/borrow is reported only on `carry_out_o`.
- Reset, asserted at any time including mid-RUN:
  - State goes to IDLE and `k` to 0.
  - `out_valid_o`=0, `in_ready_o`=1.
  - `sum_o`=0, `carry_out_o`=0, `overflow_o`=0.
  - The operation in flight is discarded.

## Timing
- Accept at edge T. Words are processed on edges T+1..T+WORD_COUNT. `out_valid_o` rises after edge T+WORD_COUNT, giving a latency of WORD_COUNT cycles.
- Result handshake at edge R. Without the macro, `in_ready_o` is 1 from after R, so the next accept is at R+1 or later. Throughput is one operation per WORD_COUNT+2 cycles when both sides are always ready.
- `in_ready_o` and `out_valid_o` are decoded from registered state only; they have no combinational path from `in_valid_i` or `out_ready_i`, except as noted under Configuration.
- Stalling `out_ready_i` low holds DONE indefinitely. No result is ever dropped or overwritten.

## Configuration
- `ADD_SUB_MULTIWORD_BACK_TO_BACK_EN` defined:
  - In DONE, `in_ready_o` = `out_ready_i`, a combinational path.
  - A simultaneous result handshake and input accept goes DONE→RUN directly and loads the new operands at that same edge.
  - Throughput becomes one operation per WORD_COUNT+1 cycles.
- Not defined: `in_ready_o` is 1 only in IDLE, as described under Timing.

## Test plan
Test plan uses WORD_WIDTH=8 and WORD_COUNT=4.
- Add 0x000000FF + 0x00000001, cin=0 -> `sum_o`=0x00000100, carry=0, ovf=0; `out_valid_o` exactly 4 cycles after accept.
- Add 0xFFFFFFFF + 0x00000001 -> 0x00000000, carry=1, ovf=0. Add 0x7FFFFFFF + 0x00000001 -> 0x80000000, carry=0, ovf=1.
- Subtract 0x00000000 − 0x00000001, cin=0 -> 0xFFFFFFFF, borrow=1, ovf=0. Subtract 0x80000000 − 0x00000001 -> 0x7FFFFFFF, borrow=0, ovf=1. Subtract 0x00000010 − 0x00000001, cin=1 -> 0x0000000E.
- Hold `out_ready_i`=0 for 5 cycles in DONE -> outputs stable and `in_ready_o`=0. Then with both sides always ready: accepts are 6 cycles apart without the macro and 5 cycles apart with it.
- Assert `rst_ni`=0 while k=2 -> `out_valid_o`=0 and all outputs 0 immediately. After release, `in_ready_o`=1 and no stale result ever appears.
- 1000 random operands and modes -> results match a 32-bit reference model.

Source files
------------

// File: rtl/add_sub_multiword_seq.sv
// Word-serial multi-precision adder/subtractor around one add_sub_binary word stage.
// Define ADD_SUB_MULTIWORD_BACK_TO_BACK_EN to allow a direct DONE->RUN turnaround.
module add_sub_binary #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             add_sub_i,
  input  logic             carry_in_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_out_o,
  output logic             overflow_o
);
  logic [WIDTH-1:0] w_b;
  logic             w_cin;
  logic [WIDTH:0]   w_full;

  // Subtract is A + ~B + ~borrow; the carry out is inverted back into a borrow.
  assign w_b         = B_i ^ {WIDTH{add_sub_i}};
  assign w_cin       = carry_in_i ^ add_sub_i;
  assign w_full      = {1'b0, A_i} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};
  assign sum_o       = w_full[WIDTH-1:0];
  assign carry_out_o = w_full[WIDTH] ^ add_sub_i;
  assign overflow_o  = (A_i[WIDTH-1] == w_b[WIDTH-1]) && (w_full[WIDTH-1] != A_i[WIDTH-1]);
endmodule

module add_sub_multiword_seq #(
  parameter int WORD_WIDTH = 8,
  parameter int WORD_COUNT = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic                             add_sub_i,
  input  logic                             carry_in_i,
  input  logic [WORD_COUNT*WORD_WIDTH-1:0] A_i,
  input  logic [WORD_COUNT*WORD_WIDTH-1:0] B_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [WORD_COUNT*WORD_WIDTH-1:0] sum_o,
  output logic                             carry_out_o,
  output logic                             overflow_o
);
  localparam int TW = WORD_COUNT * WORD_WIDTH;
  localparam int KW = $clog2(WORD_COUNT);

  // state | meaning
  // IDLE  | waiting for an operation, in_ready_o=1
  // RUN   | processing word r_k, LSW first
  // DONE  | result held until out_ready_i
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [TW-1:0]   r_a, r_b, r_sum;
  logic            r_sub, r_carry, r_cout, r_ovf;
  logic [KW-1:0]   r_k;
  logic            w_accept, w_last;
  logic [WORD_WIDTH-1:0] w_a_word, w_b_word, w_sum_word;
  logic            w_cout_word, w_ovf_word;

  assign w_accept = in_valid_i && in_ready_o;
  assign w_last   = (r_k == KW'(WORD_COUNT - 1));
  assign w_a_word = r_a[WORD_WIDTH-1:0];
  assign w_b_word = r_b[WORD_WIDTH-1:0] ^ {WORD_WIDTH{r_sub}};

  add_sub_binary #(.WIDTH(WORD_WIDTH)) u_word (
    .A_i         (w_a_word),
    .B_i         (w_b_word),
    .add_sub_i   (1'b0),
    .carry_in_i  (r_carry),
    .sum_o       (w_sum_word),
    .carry_out_o (w_cout_word),
    .overflow_o  (w_ovf_word)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) w_next = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid_o = 1'b1;
`ifdef ADD_SUB_MULTIWORD_BACK_TO_BACK_EN
        in_ready_o = out_ready_i;
`endif
        if (w_accept)         w_next = S_RUN;
        else if (out_ready_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_k     <= '0;
    end else if (w_accept) begin
      r_a     <= A_i;
      r_b     <= B_i;
      r_sub   <= add_sub_i;
      r_carry <= carry_in_i ^ add_sub_i;
      r_k     <= '0;
    end else if (r_state == S_RUN) begin
      // Operands shift down so the active word is always at the bottom;
      // the result fills from the top and lands aligned after the last word.
      r_a     <= r_a >> WORD_WIDTH;
      r_b     <= r_b >> WORD_WIDTH;
      r_sum   <= {w_sum_word, r_sum[TW-1:WORD_WIDTH]};
      r_carry <= w_cout_word;
      r_k     <= r_k + KW'(1);
      if (w_last) begin
        r_cout <= w_cout_word ^ r_sub;
        r_ovf  <= w_ovf_word;
      end
    end
  end

  assign sum_o       = r_sum;
  assign carry_out_o = r_cout;
  assign overflow_o  = r_ovf;
endmodule
